// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter and sequencer for the
// external system bus. It grants one owner at a time and holds the bus until
// the slave reports ready. It then returns read data and a one-cycle done pulse.
// Optional macro BUS_ARB_TIMEOUT_EN builds an ACCESS watchdog of TIMEOUT_CYCLES.
// Ports:
//   i_cpu_clk, i_rst         : clock, synchronous active-high reset
//   i_req/we/addr/data{0,1}  : requester access (held until done)
//   o_data/done/err{0,1}     : per-requester read data, done pulse, abort flag
//   o_grant                  : one-hot owner, 00 when idle
//   o_bus_clk/we/addr/data   : bus strobe and access registers
//   i_bus_data, i_bus_data_ready : slave read data and completion
module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    output logic              o_done0,
    output logic              o_done1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [1:0]        o_grant,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          grant_q, grant_d;
    logic                bus_clk_q, bus_clk_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [DATA_W-1:0]   data0_q, data0_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                pick1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         cnt_inc;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;

    assign cnt_inc = cnt_q + 16'd1;
`else
    logic                unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        bus_clk_d  = bus_clk_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        // On a tie, requester 1 wins only if requester 0 had the last grant.
        pick1      = i_req1 && (!i_req0 || !last_q);
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    bus_we_d   = pick1 ? i_we1 : i_we0;
                    bus_addr_d = pick1 ? i_addr1 : i_addr0;
                    bus_data_d = pick1 ? i_data1 : i_data0;
                    bus_clk_d  = 1'b1;
                    grant_d    = pick1 ? 2'b10 : 2'b01;
                    last_d     = pick1;
                    state_d    = ST_ACCESS;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (i_bus_data_ready) begin
                    if (!bus_we_q) begin
                        if (grant_q[1]) data1_d = i_bus_data;
                        else            data0_d = i_bus_data;
                    end
                    done0_d   = grant_q[0];
                    done1_d   = grant_q[1];
                    bus_clk_d = 1'b0;
                    state_d   = ST_DONE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_inc == TO_LIM) begin
                    if (grant_q[1]) data1_d = '1;
                    else            data0_d = '1;
                    done0_d   = grant_q[0];
                    done1_d   = grant_q[1];
                    err0_d    = grant_q[0];
                    err1_d    = grant_q[1];
                    bus_clk_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            ST_DONE: begin
                grant_d  = 2'b00;
                bus_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            grant_q    <= '0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            bus_clk_q  <= bus_clk_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
`endif
        end
    end

    assign o_data0    = data0_q;
    assign o_data1    = data1_q;
    assign o_done0    = done0_q;
    assign o_done1    = done1_q;
    assign o_grant    = grant_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign o_err0     = err0_q;
    assign o_err1     = err1_q;
`else
    assign o_err0     = 1'b0;
    assign o_err1     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic for bus_arbiter,
// checked cycle by cycle against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req [2];
    logic          we [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] bus_rdata;
    logic          ready;

    logic [DW-1:0] o_data0, o_data1;
    logic          o_done0, o_done1, o_err0, o_err1;
    logic [1:0]    o_grant;
    logic          o_bus_clk, o_bus_we;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_data;

    bus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_cpu_clk(clk),
        .i_rst(rst),
        .i_req0(req[0]),
        .i_req1(req[1]),
        .i_we0(we[0]),
        .i_we1(we[1]),
        .i_addr0(addr[0]),
        .i_addr1(addr[1]),
        .i_data0(wdat[0]),
        .i_data1(wdat[1]),
        .o_data0(o_data0),
        .o_data1(o_data1),
        .o_done0(o_done0),
        .o_done1(o_done1),
        .o_err0(o_err0),
        .o_err1(o_err1),
        .o_grant(o_grant),
        .o_bus_clk(o_bus_clk),
        .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr),
        .o_bus_data(o_bus_data),
        .i_bus_data(bus_rdata),
        .i_bus_data_ready(ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether we are in the turnaround
    // cycle, how long the owner has waited, and the expected outputs.
    int            m_own;
    bit            m_turn;
    bit            m_last;
    int            m_wait;
    logic [1:0]    e_grant;
    bit            e_clk, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd [2];
    bit            e_done [2];
    bit            e_err [2];

    task automatic finish_access(input bit abort);
        e_done[m_own] = 1'b1;
        e_err[m_own]  = abort;
        if (abort)       e_rd[m_own] = '1;
        else if (!e_we)  e_rd[m_own] = bus_rdata;
        e_clk  = 1'b0;
        m_turn = 1'b1;
        m_own  = -1;
    endtask

    task automatic model_edge();
        int w;
        if (rst) begin
            m_own = -1; m_turn = 0; m_last = 1; m_wait = 0;
            e_grant = 0; e_clk = 0; e_we = 0; e_addr = 0; e_wd = 0;
            for (int i = 0; i < 2; i++) begin
                e_rd[i] = 0; e_done[i] = 0; e_err[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e_done[i] = 0; e_err[i] = 0;
        end
        if (m_turn) begin
            m_turn = 0; e_grant = 0; e_we = 0;
        end else if (m_own < 0) begin
            if (req[0] || req[1]) begin
                if (req[0] && req[1]) w = m_last ? 0 : 1;
                else                  w = req[1] ? 1 : 0;
                m_last  = (w == 1);
                m_own   = w;
                m_wait  = 0;
                e_we    = we[w];
                e_addr  = addr[w];
                e_wd    = wdat[w];
                e_clk   = 1'b1;
                e_grant = 2'(1 << w);
            end
        end else if (ready) begin
            finish_access(1'b0);
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO) finish_access(1'b1);
`endif
        end
    endtask

    task automatic compare_all();
        chk("grant",   32'(o_grant),    32'(e_grant));
        chk("bus_clk", 32'(o_bus_clk),  32'(e_clk));
        chk("bus_we",  32'(o_bus_we),   32'(e_we));
        chk("bus_addr", o_bus_addr,     e_addr);
        chk("bus_data", o_bus_data,     e_wd);
        chk("data0",   o_data0,         e_rd[0]);
        chk("data1",   o_data1,         e_rd[1]);
        chk("done0",   32'(o_done0),    32'(e_done[0]));
        chk("done1",   32'(o_done1),    32'(e_done[1]));
        chk("err0",    32'(o_err0),     32'(e_err[0]));
        chk("err1",    32'(o_err1),     32'(e_err[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        req[0] = 0; req[1] = 0; ready = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic new_req(input int i);
        req[i]  = 1'b1;
        we[i]   = 1'($urandom_range(0, 1));
        addr[i] = $urandom;
        wdat[i] = $urandom;
    endtask

    logic [AW-1:0] order [$];
    logic [AW-1:0] exp_order [3];
    int            hi;
    bit            pend [2];

    initial begin
        rst = 1; ready = 0; bus_rdata = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; we[i] = 0; addr[i] = 0; wdat[i] = 0;
        end
        tick();
        tick();
        rst = 0;

        // Single read with ready raised after three strobe cycles.
        req[0] = 1; we[0] = 0; addr[0] = 32'h0000_1000; wdat[0] = 0;
        bus_rdata = 32'hDEAD_BEEF;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hi += int'(o_bus_clk);
        end
        ready = 1;
        tick();
        chk("rd_strobe_len", 32'(hi), 32'd3);
        chk("rd_done", 32'(o_done0), 32'd1);
        chk("rd_data", o_data0, 32'hDEAD_BEEF);
        req[0] = 0; ready = 0;
        tick();
        chk("rd_done_pulse", 32'(o_done0), 32'd0);
        chk("rd_grant_idle", 32'(o_grant), 32'd0);
        chk("rd_data_hold", o_data0, 32'hDEAD_BEEF);

        // Tie after reset: strict alternation starting with requester 0.
        do_reset();
        req[0] = 1; we[0] = 1; addr[0] = 32'h10; wdat[0] = 32'h11;
        req[1] = 1; we[1] = 1; addr[1] = 32'h20; wdat[1] = 32'h22;
        ready = 1;
        order.delete();
        for (int i = 0; i < 9; i++) begin
            tick();
            if (o_bus_clk) order.push_back(o_bus_addr);
        end
        exp_order[0] = 32'h10;
        exp_order[1] = 32'h20;
        exp_order[2] = 32'h10;
        chk("tie_count", 32'(order.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("tie_order", (i < order.size()) ? order[i] : 32'hx,
                exp_order[i]);

        // Requester input changes during ACCESS are ignored.
        do_reset();
        req[1] = 1; we[1] = 1; addr[1] = 32'h40; wdat[1] = 32'h99;
        tick();
        addr[1] = 32'h44;
        tick();
        tick();
        chk("mid_addr", o_bus_addr, 32'h40);
        ready = 1;
        tick();
        chk("mid_done", 32'(o_done1), 32'd1);
        chk("mid_addr_end", o_bus_addr, 32'h40);
        req[1] = 0; ready = 0;
        tick();

        // Reset during ACCESS abandons the access; next tie goes to 0.
        req[0] = 1; we[0] = 0; addr[0] = 32'h80;
        tick();
        tick();
        rst = 1;
        tick();
        chk("rst_no_done", 32'(o_done0), 32'd0);
        chk("rst_clk", 32'(o_bus_clk), 32'd0);
        rst = 0;
        req[0] = 1; req[1] = 1;
        tick();
        chk("rst_tie_grant", 32'(o_grant), 32'd1);
        do_reset();

`ifdef BUS_ARB_TIMEOUT_EN
        req[0] = 1; we[0] = 0; addr[0] = 32'h100; ready = 0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("to_early", 32'(o_done0), 32'd0);
        tick();
        chk("to_done", 32'(o_done0), 32'd1);
        chk("to_err", 32'(o_err0), 32'd1);
        chk("to_data", o_data0, 32'hFFFF_FFFF);
        req[0] = 0;
        tick();
        req[0] = 1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        ready = 1; bus_rdata = 32'h1234_5678;
        tick();
        chk("to_race_done", 32'(o_done0), 32'd1);
        chk("to_race_err", 32'(o_err0), 32'd0);
        chk("to_race_data", o_data0, 32'h1234_5678);
        do_reset();
`else
        req[0] = 1; we[0] = 0; addr[0] = 32'h100; ready = 0;
        tick();
        for (int i = 0; i < 1000; i++) tick();
        chk("wait_clk", 32'(o_bus_clk), 32'd1);
        chk("wait_err", 32'(o_err0), 32'd0);
        chk("wait_done", 32'(o_done0), 32'd0);
        do_reset();
`endif

        // Randomized traffic with back-to-back requests and rare resets.
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && e_done[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        pend[i] = 0; req[i] = 0;
                    end else begin
                        new_req(i);
                    end
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    new_req(i);
                end else if (pend[i] && $urandom_range(0, 3) == 0) begin
                    addr[i] = $urandom;
                    wdat[i] = $urandom;
                end
            end
            ready     = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
